gtfmac_vnc_rx_lat_run_ctrl: RTL and testbench

//  Sequences latency-measurement runs on the RX monitor path. Sits after the RX GTFMAC

---
 rtl/gtfmac_vnc_rx_lat_run_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_gtfmac_vnc_rx_lat_run_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gtfmac_vnc_rx_lat_run_ctrl.sv
// Purpose: sequences latency-measurement runs on the RX monitor path. It arms a run,
//          starts it at the measured-run marker, counts N frames (or runs until abort),
//          and gates downstream latency capture through meas_enable.
// Ports:
//   rx_axis_clk / rx_axis_rst_n   clock, asynchronous active-low reset
//   ctl_run_start / ctl_run_abort run control pulses
//   ctl_frames_per_run            frames per run (0 = unbounded)
//   ctl_timeout                   idle cycles before timeout (0 = disabled)
//   din_*                         RX frame stream (ena/sop/eop/err/empty)
//   rx_start_measured_run         run start marker, coincident with a din_ena word
//   meas_enable, run_active, run_done, run_aborted, run_timeout   run status
//   stat_frames_rcvd/err/empty    saturating per-run frame statistics
//   run_state                     00 IDLE, 01 ARMED, 10 RUN, 11 FLUSH
module gtfmac_vnc_rx_lat_run_ctrl #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned TMO_W = 24
) (
  input  logic             rx_axis_clk,
  input  logic             rx_axis_rst_n,
  input  logic             ctl_run_start,
  input  logic             ctl_run_abort,
  input  logic [CNT_W-1:0] ctl_frames_per_run,
  input  logic [TMO_W-1:0] ctl_timeout,
  input  logic             din_ena,
  input  logic             din_sop,
  input  logic             din_eop,
  input  logic             din_err,
  input  logic             din_empty,
  input  logic             rx_start_measured_run,
  output logic             meas_enable,
  output logic             run_active,
  output logic             run_done,
  output logic             run_aborted,
  output logic             run_timeout,
  output logic [CNT_W-1:0] stat_frames_rcvd,
  output logic [CNT_W-1:0] stat_frames_err,
  output logic [CNT_W-1:0] stat_frames_empty,
  output logic [1:0]       run_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_RUN   = 2'b10,
    ST_FLUSH = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic             in_frame_q, in_frame_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [TMO_W-1:0] t_q, t_d;
  logic [TMO_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0] rcvd_q, rcvd_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] empty_q, empty_d;
  logic             aborted_q, aborted_d;
  logic             timeout_q, timeout_d;
  logic             meas_q, active_q, done_q;
  logic [1:0]       run_state_q;

  logic             eop_ev_c;
  logic             tmo_hit_c;
  logic             final_c;
  logic             clr_stats_c;
  logic             count_en_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Frame-level events shared by the FSM and the statistics
  assign eop_ev_c  = din_ena & din_eop;
  assign tmo_hit_c = (t_q != '0) && !din_ena && (idle_q == t_q - TMO_W'(1));
  // The current eop is the last frame of a bounded run
  assign final_c   = (n_q != '0) && (rcvd_q == n_q - CNT_W'(1));

  // Run sequencing: next state, flags and latched configuration
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    t_d         = t_q;
    aborted_d   = aborted_q;
    timeout_d   = timeout_q;
    clr_stats_c = 1'b0;
    count_en_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctl_run_start && !ctl_run_abort) begin
          state_d     = ST_ARMED;
          n_d         = ctl_frames_per_run;
          t_d         = ctl_timeout;
          aborted_d   = 1'b0;
          timeout_d   = 1'b0;
          clr_stats_c = 1'b1;
        end
      end
      ST_ARMED: begin
        if (ctl_run_abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (rx_start_measured_run) begin
          // A single-word marker frame is counted immediately
          count_en_c = eop_ev_c;
          state_d    = (eop_ev_c && final_c) ? ST_IDLE : ST_RUN;
        end else if (tmo_hit_c) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (eop_ev_c) begin
          count_en_c = 1'b1;
          // Final-count completion outranks a coincident abort
          if (final_c) begin
            state_d = ST_IDLE;
          end else if (ctl_run_abort) begin
            state_d   = ST_IDLE;
            aborted_d = 1'b1;
          end
        end else if (ctl_run_abort) begin
          aborted_d = 1'b1;
          state_d   = in_frame_q ? ST_FLUSH : ST_IDLE;
        end else if (tmo_hit_c) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (eop_ev_c) begin
          state_d = ST_IDLE;
        end else if (tmo_hit_c) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating frame statistics
  always_comb begin
    rcvd_d  = rcvd_q;
    err_d   = err_q;
    empty_d = empty_q;
    if (clr_stats_c) begin
      rcvd_d  = '0;
      err_d   = '0;
      empty_d = '0;
    end else if (count_en_c) begin
      rcvd_d = sat_inc(rcvd_q);
      if (din_err)   err_d   = sat_inc(err_q);
      if (din_empty) empty_d = sat_inc(empty_q);
    end
  end

  // Frame tracking and idle counter (cleared by traffic or any state change)
  always_comb begin
    in_frame_d = in_frame_q;
    if (eop_ev_c) begin
      in_frame_d = 1'b0;
    end else if (din_ena && din_sop) begin
      in_frame_d = 1'b1;
    end

    idle_d = idle_q;
    if (din_ena || (state_d != state_q)) begin
      idle_d = '0;
    end else if ((state_q != ST_IDLE) && (idle_q != '1)) begin
      idle_d = idle_q + TMO_W'(1);
    end
  end

  // State, configuration, statistics and registered outputs
  always_ff @(posedge rx_axis_clk or negedge rx_axis_rst_n) begin
    if (!rx_axis_rst_n) begin
      state_q     <= ST_IDLE;
      in_frame_q  <= 1'b0;
      n_q         <= '0;
      t_q         <= '0;
      idle_q      <= '0;
      rcvd_q      <= '0;
      err_q       <= '0;
      empty_q     <= '0;
      aborted_q   <= 1'b0;
      timeout_q   <= 1'b0;
      meas_q      <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      run_state_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      in_frame_q  <= in_frame_d;
      n_q         <= n_d;
      t_q         <= t_d;
      idle_q      <= idle_d;
      rcvd_q      <= rcvd_d;
      err_q       <= err_d;
      empty_q     <= empty_d;
      aborted_q   <= aborted_d;
      timeout_q   <= timeout_d;
      meas_q      <= (state_d == ST_RUN);
      active_q    <= (state_d != ST_IDLE);
      done_q      <= (state_q != ST_IDLE) && (state_d == ST_IDLE);
      run_state_q <= state_d;
    end
  end

  assign meas_enable       = meas_q;
  assign run_active        = active_q;
  assign run_done          = done_q;
  assign run_aborted       = aborted_q;
  assign run_timeout       = timeout_q;
  assign stat_frames_rcvd  = rcvd_q;
  assign stat_frames_err   = err_q;
  assign stat_frames_empty = empty_q;
  assign run_state         = run_state_q;

endmodule

// File: tb/tb_gtfmac_vnc_rx_lat_run_ctrl.sv
// Self-checking bench for gtfmac_vnc_rx_lat_run_ctrl: a cycle table for a basic
// bounded run, directed corner-case sequences, then randomized traffic and control
// compared every cycle against a behavioural run model.
module tb_gtfmac_vnc_rx_lat_run_ctrl;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned TMO_W = 8;
  localparam int          CMAX  = 255;
  localparam int          TMAX  = 255;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, abort, ena, sop, eop, err, emp, mk;
  logic [CNT_W-1:0] cfg_n;
  logic [TMO_W-1:0] cfg_t;
  logic             meas_enable, run_active, run_done, run_aborted, run_timeout;
  logic [CNT_W-1:0] st_rcvd, st_err, st_empty;
  logic [1:0]       run_state;

  int n_checks = 0;
  int n_fail   = 0;

  gtfmac_vnc_rx_lat_run_ctrl #(.CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .rx_axis_clk           (clk),
    .rx_axis_rst_n         (rst_n),
    .ctl_run_start         (start),
    .ctl_run_abort         (abort),
    .ctl_frames_per_run    (cfg_n),
    .ctl_timeout           (cfg_t),
    .din_ena               (ena),
    .din_sop               (sop),
    .din_eop               (eop),
    .din_err               (err),
    .din_empty             (emp),
    .rx_start_measured_run (mk),
    .meas_enable           (meas_enable),
    .run_active            (run_active),
    .run_done              (run_done),
    .run_aborted           (run_aborted),
    .run_timeout           (run_timeout),
    .stat_frames_rcvd      (st_rcvd),
    .stat_frames_err       (st_err),
    .stat_frames_empty     (st_empty),
    .run_state             (run_state)
  );

  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    start = 0; abort = 0; ena = 0; sop = 0; eop = 0; err = 0; emp = 0; mk = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input bit s, input bit e, input bit er, input bit em, input bit m);
    ena = 1; sop = s; eop = e; err = er; emp = em; mk = m;
    cyc();
    clr_in();
  endtask

  task automatic frame2(input bit er, input bit m);
    word(1, 0, 0, 0, m);
    word(0, 1, er, 0, 0);
  endtask

  task automatic pulse_start();
    start = 1;
    cyc();
    clr_in();
  endtask

  task automatic do_reset();
    clr_in();
    rst_n = 0;
    cyc();
    rst_n = 1;
    cyc();
  endtask

  function automatic logic [30:0] dut_pack();
    return {run_state, meas_enable, run_active, run_done, run_aborted, run_timeout,
            st_rcvd, st_err, st_empty};
  endfunction

  // ---------------- behavioural run model ----------------
  // states: 0 idle, 1 armed, 2 running, 3 flushing an aborted frame
  int m_st, m_n, m_t, m_idle, m_rcvd, m_err, m_emp;
  bit m_inf, m_ab, m_to, m_done;

  task automatic model_reset();
    m_st = 0; m_n = 0; m_t = 0; m_idle = 0; m_rcvd = 0; m_err = 0; m_emp = 0;
    m_inf = 0; m_ab = 0; m_to = 0; m_done = 0;
  endtask

  task automatic model_count();
    if (m_rcvd < CMAX) m_rcvd++;
    if (err && m_err < CMAX) m_err++;
    if (emp && m_emp < CMAX) m_emp++;
  endtask

  task automatic model_step();
    int  nst;
    bit  eopv, tmo, fin;
    eopv = ena && eop;
    tmo  = (m_t != 0) && !ena && (m_idle == m_t - 1);
    fin  = (m_n != 0) && (m_rcvd + 1 == m_n);
    nst  = m_st;
    if (m_st == 0) begin
      if (start && !abort) begin
        nst = 1; m_n = int'(cfg_n); m_t = int'(cfg_t);
        m_ab = 0; m_to = 0; m_rcvd = 0; m_err = 0; m_emp = 0;
      end
    end else if (m_st == 1) begin
      if (abort) begin nst = 0; m_ab = 1; end
      else if (mk) begin
        if (eopv) model_count();
        nst = (eopv && fin) ? 0 : 2;
      end else if (tmo) begin nst = 0; m_to = 1; end
    end else if (m_st == 2) begin
      if (eopv) begin
        model_count();
        if (fin) nst = 0;
        else if (abort) begin nst = 0; m_ab = 1; end
      end else if (abort) begin
        m_ab = 1;
        nst  = m_inf ? 3 : 0;
      end else if (tmo) begin nst = 0; m_to = 1; end
    end else begin
      if (eopv) nst = 0;
      else if (tmo) begin nst = 0; m_to = 1; end
    end
    if (ena || nst != m_st) m_idle = 0;
    else if (m_st != 0 && m_idle < TMAX) m_idle++;
    if (eopv) m_inf = 0;
    else if (ena && sop) m_inf = 1;
    m_done = (m_st != 0) && (nst == 0);
    m_st   = nst;
  endtask

  function automatic logic [30:0] model_pack();
    return {2'(m_st), (m_st == 2), (m_st != 0), m_done, m_ab, m_to,
            8'(m_rcvd), 8'(m_err), 8'(m_emp)};
  endfunction

  // ---------------- cycle table ----------------
  typedef struct {
    bit       start, abort, ena, sop, eop, err, mk;
    bit [1:0] st;
    bit       meas, done;
    int       rcvd, errs;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int k;
    int rf_left;
    int len;

    // N=3, T=0: marker on frame 1, three frames with the second errored
    vecs[0] = '{1,0, 0,0,0,0,0, 2'd1, 0,0, 0,0};
    vecs[1] = '{0,0, 0,0,0,0,0, 2'd1, 0,0, 0,0};
    vecs[2] = '{0,0, 1,1,0,0,1, 2'd2, 1,0, 0,0};
    vecs[3] = '{0,0, 1,0,0,0,0, 2'd2, 1,0, 0,0};
    vecs[4] = '{0,0, 1,0,1,0,0, 2'd2, 1,0, 1,0};
    vecs[5] = '{0,0, 1,1,0,0,0, 2'd2, 1,0, 1,0};
    vecs[6] = '{0,0, 1,0,1,1,0, 2'd2, 1,0, 2,1};
    vecs[7] = '{0,0, 0,0,0,0,0, 2'd2, 1,0, 2,1};
    vecs[8] = '{0,0, 1,1,1,0,0, 2'd0, 0,1, 3,1};
    vecs[9] = '{0,0, 0,0,0,0,0, 2'd0, 0,0, 3,1};

    clr_in();
    cfg_n = 8'd3;
    cfg_t = 8'd0;
    rst_n = 0;
    #12;
    chk("reset_outputs", 64'(dut_pack()), 64'd0);
    @(negedge clk);
    rst_n = 1;
    cyc();

    for (int i = 0; i < 10; i++) begin
      start = vecs[i].start; abort = vecs[i].abort; ena = vecs[i].ena;
      sop = vecs[i].sop; eop = vecs[i].eop; err = vecs[i].err; mk = vecs[i].mk;
      cyc();
      clr_in();
      chk($sformatf("tbl%0d_state", i), 64'(run_state), 64'(vecs[i].st));
      chk($sformatf("tbl%0d_meas", i), 64'(meas_enable), 64'(vecs[i].meas));
      chk($sformatf("tbl%0d_done", i), 64'(run_done), 64'(vecs[i].done));
      chk($sformatf("tbl%0d_rcvd", i), 64'(st_rcvd), 64'(vecs[i].rcvd));
      chk($sformatf("tbl%0d_err", i), 64'(st_err), 64'(vecs[i].errs));
    end
    chk("tbl_empty", 64'(st_empty), 64'd0);

    // N=0: ten frames, start ignored while running, abort between frames
    cfg_n = 8'd0;
    pulse_start();
    frame2(0, 1);
    for (int i = 0; i < 9; i++) frame2(0, 0);
    pulse_start();
    chk("start_in_run_state", 64'(run_state), 64'd2);
    chk("start_in_run_rcvd", 64'(st_rcvd), 64'd10);
    abort = 1;
    cyc();
    clr_in();
    chk("unb_abort_state", 64'(run_state), 64'd0);
    chk("unb_abort_done", 64'(run_done), 64'd1);
    chk("unb_abort_flag", 64'(run_aborted), 64'd1);
    chk("unb_abort_rcvd", 64'(st_rcvd), 64'd10);

    // start together with abort in IDLE leaves everything alone
    start = 1; abort = 1;
    cyc();
    clr_in();
    chk("start_abort_state", 64'(run_state), 64'd0);
    chk("start_abort_flag", 64'(run_aborted), 64'd1);
    chk("start_abort_rcvd", 64'(st_rcvd), 64'd10);

    // abort mid-frame goes through FLUSH and drops that frame
    pulse_start();
    chk("restart_clears_abort", 64'(run_aborted), 64'd0);
    frame2(0, 1);
    word(1, 0, 0, 0, 0);
    abort = 1;
    cyc();
    clr_in();
    chk("flush_state", 64'(run_state), 64'd3);
    chk("flush_meas", 64'(meas_enable), 64'd0);
    chk("flush_active", 64'(run_active), 64'd1);
    word(0, 0, 0, 0, 0);
    chk("flush_hold_done", 64'(run_done), 64'd0);
    word(0, 1, 1, 0, 0);
    chk("flush_end_state", 64'(run_state), 64'd0);
    chk("flush_end_done", 64'(run_done), 64'd1);
    chk("flush_end_rcvd", 64'(st_rcvd), 64'd1);
    chk("flush_end_err", 64'(st_err), 64'd0);

    // T=100 with no traffic: timeout exactly 100 cycles after ARMED shows
    cfg_t = 8'd100;
    pulse_start();
    chk("tmo_armed", 64'(run_state), 64'd1);
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      cyc();
      if (run_timeout) begin k = i; break; end
    end
    chk("tmo_latency", 64'(k), 64'd100);
    chk("tmo_done", 64'(run_done), 64'd1);
    chk("tmo_state", 64'(run_state), 64'd0);
    cfg_t = 8'd0;

    // N=5 with abort on the 5th eop: completion wins
    cfg_n = 8'd5;
    pulse_start();
    chk("n5_clears_timeout", 64'(run_timeout), 64'd0);
    frame2(0, 1);
    for (int i = 0; i < 3; i++) frame2(0, 0);
    word(1, 0, 0, 0, 0);
    abort = 1;
    word(0, 1, 0, 0, 0);
    chk("n5_state", 64'(run_state), 64'd0);
    chk("n5_done", 64'(run_done), 64'd1);
    chk("n5_rcvd", 64'(st_rcvd), 64'd5);
    chk("n5_not_aborted", 64'(run_aborted), 64'd0);

    // counters saturate at all-ones
    cfg_n = 8'd0;
    pulse_start();
    word(1, 1, 1, 1, 1);
    for (int i = 0; i < 259; i++) word(1, 1, 1, 1, 0);
    chk("sat_rcvd", 64'(st_rcvd), 64'd255);
    chk("sat_err", 64'(st_err), 64'd255);
    chk("sat_empty", 64'(st_empty), 64'd255);
    chk("sat_state", 64'(run_state), 64'd2);

    // asynchronous reset in RUN, then a fresh start
    word(1, 0, 0, 0, 0);
    #3;
    rst_n = 0;
    #1;
    chk("async_rst_outputs", 64'(dut_pack()), 64'd0);
    @(negedge clk);
    rst_n = 1;
    cyc();
    pulse_start();
    chk("post_rst_armed", 64'(run_state), 64'd1);
    chk("post_rst_active", 64'(run_active), 64'd1);

    // randomized traffic and control against the model
    do_reset();
    model_reset();
    rf_left = 0;
    cfg_n = 8'd2;
    cfg_t = 8'd0;
    for (int c = 0; c < 4000; c++) begin
      clr_in();
      if ($urandom_range(0, 99) < 5) start = 1;
      if ($urandom_range(0, 99) < 2) abort = 1;
      if ($urandom_range(0, 99) < 3) begin
        cfg_n = 8'($urandom_range(0, 6));
        cfg_t = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(2, 25));
      end
      if (rf_left == 0) begin
        if ($urandom_range(0, 99) < 40) begin
          len = int'($urandom_range(1, 4));
          ena = 1; sop = 1;
          mk = ($urandom_range(0, 99) < 35);
          rf_left = len;
        end
      end else if ($urandom_range(0, 99) < 70) begin
        ena = 1;
      end
      if (ena) begin
        rf_left--;
        if (rf_left == 0) begin
          eop = 1;
          err = ($urandom_range(0, 3) == 0);
          emp = ($urandom_range(0, 5) == 0);
        end
      end
      model_step();
      cyc();
      chk($sformatf("rand_cycle%0d", c), 64'(dut_pack()), 64'(model_pack()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
